// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I/M execute unit with registered result and iterative MUL/DIV engine
//
// Decodes alu_op/funct3/funct7 internally. Base ALU ops complete in one cycle;
// MUL*/DIV*/REM* use a radix-2 shift-add / restoring-divide engine taking XLEN
// cycles. Division by zero and signed overflow are resolved in a single cycle.
//
// Optional feature macro: ALU_MDU_EN (M-extension decode and MUL/DIV engine).
// Without it, any M-extension encoding returns result 0 with illegal set.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake
//   alu_op                00 ADD, x1 SUB (priority), 10 R-format decode
//   funct3, funct7_b5,
//   funct7_b0             instruction fields [14:12], [30], [25]
//   op_a, op_b            operands (rs1, rs2/imm)
//   out_valid / out_ready result handshake
//   result, zero, illegal registered result, result==0, undefined encoding
//   busy                  iterative engine active

module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic            funct7_b0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    logic            accept;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] sc_result;
    logic            sc_illegal;
    logic            start_iter;
    logic            iter_done;
    logic [XLEN-1:0] iter_result;

    assign accept = in_valid && in_ready;
    assign shamt  = op_b[SW-1:0];

    // Single-cycle decode; start_iter flags an op that must go to the engine.
    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        start_iter = 1'b0;
        if (alu_op[0]) begin
            sc_result = op_a - op_b;
        end else if (!alu_op[1]) begin
            sc_result = op_a + op_b;
        end else if (!funct7_b0) begin
            case ({funct7_b5, funct3})
                4'b0000: sc_result = op_a + op_b;
                4'b1000: sc_result = op_a - op_b;
                4'b0001: sc_result = op_a << shamt;
                4'b0010: sc_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                4'b0011: sc_result = {{(XLEN-1){1'b0}}, op_a < op_b};
                4'b0100: sc_result = op_a ^ op_b;
                4'b0101: sc_result = op_a >> shamt;
                4'b1101: sc_result = $unsigned($signed(op_a) >>> shamt);
                4'b0110: sc_result = op_a | op_b;
                4'b0111: sc_result = op_a & op_b;
                default: sc_illegal = 1'b1;
            endcase
        end else begin
`ifdef ALU_MDU_EN
            if (funct7_b5) begin
                sc_illegal = 1'b1;
            end else if (!funct3[2]) begin
                start_iter = 1'b1;
            end else if (op_b == '0) begin
                // divide by zero: quotient all-ones, remainder = dividend
                sc_result = funct3[1] ? op_a : ALL_ONES;
            end else if (!funct3[0] && op_a == MIN_VAL && op_b == ALL_ONES) begin
                // signed overflow: quotient MIN, remainder 0
                sc_result = funct3[1] ? '0 : MIN_VAL;
            end else begin
                start_iter = 1'b1;
            end
`else
            sc_illegal = 1'b1;
`endif
        end
    end

`ifdef ALU_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t              state, state_next;
    logic [SW-1:0]       count;
    logic [2*XLEN-1:0]   acc, acc_step, prod_signed;
    logic [XLEN-1:0]     opnd;
    logic                neg_res;
    logic                sel_upper;   // MULH* high half, or REM* remainder
    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, div_trial;
    logic [XLEN-1:0]     quo_s, rem_s;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (!funct3[2]) begin
            a_signed = (funct3 != 3'b011);
            b_signed = !funct3[1];
        end else begin
            a_signed = !funct3[0];
            b_signed = !funct3[0];
        end
    end

    assign a_neg = a_signed && op_a[XLEN-1];
    assign b_neg = b_signed && op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // acc holds {high, low}: multiply = {partial product, remaining multiplier},
    // divide = {partial remainder, dividend bits shifting into quotient}.
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};

    always_comb begin
        acc_step = acc;
        if (state == S_MUL) begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end else if (state == S_DIV) begin
            acc_step = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    assign prod_signed = neg_res ? -acc_step : acc_step;
    assign quo_s       = neg_res ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    assign rem_s       = neg_res ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    always_comb begin
        iter_result = '0;
        if (state == S_MUL) begin
            iter_result = sel_upper ? prod_signed[2*XLEN-1:XLEN] : prod_signed[XLEN-1:0];
        end else if (state == S_DIV) begin
            iter_result = sel_upper ? rem_s : quo_s;
        end
    end

    assign busy      = (state != S_IDLE);
    assign iter_done = busy && (&count);
    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && start_iter) state_next = funct3[2] ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (&count) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg_res   <= 1'b0;
            sel_upper <= 1'b0;
        end else if (accept && start_iter) begin
            count     <= '0;
            acc       <= {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
            opnd      <= funct3[2] ? b_mag : a_mag;
            neg_res   <= (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            sel_upper <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
        end else if (busy) begin
            acc   <= acc_step;
            count <= count + 1'b1;
        end
    end
`else
    assign busy        = 1'b0;
    assign iter_done   = 1'b0;
    assign iter_result = '0;
    assign in_ready    = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !start_iter) begin
                out_valid <= 1'b1;
                result    <= sc_result;
                zero      <= (sc_result == '0);
                illegal   <= sc_illegal;
            end else if (iter_done) begin
                out_valid <= 1'b1;
                result    <= iter_result;
                zero      <= (iter_result == '0);
                illegal   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

`ifdef ALU_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        funct7_b0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .funct7_b0 (funct7_b0),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        b5;
        logic        b0;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        logic        is_m;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          due;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [1:0] op, input logic [2:0] f3,
                       input logic b5, input logic b0, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic ill,
                       input logic is_m, input int lat);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.b5 = b5; v.b0 = b0;
        v.a = a; v.b = b; v.res = res; v.ill = ill; v.is_m = is_m; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Drive one op when in_ready allows it; push its expectation.
    task automatic send(input vec_t v, output int waited);
        exp_t e;
        int   lat;
        waited = 0;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk({"accept_", v.name}, {31'd0, in_ready}, 32'd1);
        if (!in_ready) return;
        if (v.is_m && !MDU) begin
            e.res = 32'd0; e.ill = 1'b1; lat = 0;
        end else begin
            e.res = v.res; e.ill = v.ill; lat = v.lat;
        end
        e.name = v.name;
        e.zero = (e.res == 32'd0);
        e.due  = cyc + 1 + lat;
        alu_op = v.op; funct3 = v.f3; funct7_b5 = v.b5; funct7_b0 = v.b0;
        op_a = v.a; op_b = v.b; in_valid = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic idle_wait();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Compare each result on the first negedge it is visible; the flag is
    // re-armed once the result is seen to drain at the following posedge.
    initial begin
        bit   shown = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                shown = 1'b0;
            end else if (out_valid && !shown) begin
                shown = 1'b1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got result %h with no op pending", result);
                end else begin
                    e = exp_q.pop_front();
                    chk({"res_", e.name}, result, e.res);
                    chk({"zero_", e.name}, {31'd0, zero}, {31'd0, e.zero});
                    chk({"ill_", e.name}, {31'd0, illegal}, {31'd0, e.ill});
                    chk({"lat_", e.name}, cyc, e.due);
                end
            end
            #2;
            if (!out_valid || out_ready) shown = 1'b0;
        end
    end

    initial begin
        int   w;
        int   n;
        int   viol;
        vec_t v;

        add("add_5_7",   2'b00, 3'b000, 0, 0, 32'd5,        32'd7,        32'h0000000C, 0, 0, 0);
        add("bsub_9_9",  2'b01, 3'b101, 1, 1, 32'd9,        32'd9,        32'h00000000, 0, 0, 0);
        add("bsub_11",   2'b11, 3'b111, 0, 1, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 0);
        add("add_wrap",  2'b10, 3'b000, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 0, 0, 0);
        add("sub_wrap",  2'b10, 3'b000, 1, 0, 32'd0,        32'd1,        32'hFFFFFFFF, 0, 0, 0);
        add("sll_mask",  2'b10, 3'b001, 0, 0, 32'd1,        32'd35,       32'h00000008, 0, 0, 0);
        add("slt",       2'b10, 3'b010, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h00000001, 0, 0, 0);
        add("sltu",      2'b10, 3'b011, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 0, 0, 0);
        add("xor",       2'b10, 3'b100, 0, 0, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0, 0, 0);
        add("srl",       2'b10, 3'b101, 0, 0, 32'h80000000, 32'd4,        32'h08000000, 0, 0, 0);
        add("sra",       2'b10, 3'b101, 1, 0, 32'h80000000, 32'd4,        32'hF8000000, 0, 0, 0);
        add("or",        2'b10, 3'b110, 0, 0, 32'h000000A0, 32'h00000005, 32'h000000A5, 0, 0, 0);
        add("and",       2'b10, 3'b111, 0, 0, 32'h0000FF0F, 32'h00000FF0, 32'h00000F00, 0, 0, 0);
        add("ill_1001",  2'b10, 3'b001, 1, 0, 32'd3,        32'd4,        32'h00000000, 1, 0, 0);
        add("ill_1111",  2'b10, 3'b111, 1, 0, 32'd3,        32'd4,        32'h00000000, 1, 0, 0);
        add("ill_m_b5",  2'b10, 3'b000, 1, 1, 32'd3,        32'd4,        32'h00000000, 1, 0, 0);
        add("mul",       2'b10, 3'b000, 0, 1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 0, 1, 32);
        add("mulh_m1",   2'b10, 3'b001, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1, 32);
        add("mulhu_m1",  2'b10, 3'b011, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 32);
        add("mulhsu",    2'b10, 3'b010, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32);
        add("mulh_min",  2'b10, 3'b001, 0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1, 32);
        add("div_by0",   2'b10, 3'b100, 0, 1, 32'd7,        32'd0,        32'hFFFFFFFF, 0, 1, 0);
        add("rem_by0",   2'b10, 3'b110, 0, 1, 32'd7,        32'd0,        32'h00000007, 0, 1, 0);
        add("divu_by0",  2'b10, 3'b101, 0, 1, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1, 0);
        add("remu_by0",  2'b10, 3'b111, 0, 1, 32'd5,        32'd0,        32'h00000005, 0, 1, 0);
        add("div_ovf",   2'b10, 3'b100, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 0);
        add("rem_ovf",   2'b10, 3'b110, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0);
        add("rem_m7_2",  2'b10, 3'b110, 0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 1, 32);
        add("div_m7_2",  2'b10, 3'b100, 0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 1, 32);
        add("div_7_m2",  2'b10, 3'b100, 0, 1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 1, 32);
        add("rem_7_m2",  2'b10, 3'b110, 0, 1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 0, 1, 32);
        add("divu_big",  2'b10, 3'b101, 0, 1, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 0, 1, 32);
        add("remu_big",  2'b10, 3'b111, 0, 1, 32'hFFFFFFF9, 32'd2,        32'h00000001, 0, 1, 32);
        add("divu_min",  2'b10, 3'b101, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 1, 32);
        add("remu_min",  2'b10, 3'b111, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 32);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct3 = 3'b000; funct7_b5 = 1'b0; funct7_b0 = 1'b0;
        op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    result, 32'd0);
        chk("rst_zero",      {31'd0, zero}, 32'd0);
        chk("rst_illegal",   {31'd0, illegal}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i], w);
        end
        idle_wait();

        // Iterative op keeps the engine busy and the input side closed.
        send(vecs[18], w);
        n = 0;
        viol = 0;
        while (busy && n < 100) begin
            if (in_ready) viol++;
            n++;
            @(negedge clk);
        end
        chk("mulhu_busy_cycles", n, MDU ? 32 : 0);
        chk("mulhu_in_ready_while_busy", viol, 0);
        idle_wait();

        // Backpressure hold, then drain with back-to-back accepts.
        out_ready = 1'b0;
        send(vecs[0], w);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid && result == 32'h0000000C && !in_ready) n++;
            @(negedge clk);
        end
        chk("bp_hold_cycles", n, 5);
        out_ready = 1'b1;
        send(vecs[10], w);
        chk("bp_release_wait", w, 0);
        send(vecs[8], w);
        chk("back_to_back_wait", w, 0);
        idle_wait();

        // Reset during a DIVU aborts it without emitting a result.
        v = vecs[31];
        v.name = "divu_abort"; v.a = 32'd100; v.b = 32'd7; v.res = 32'd14;
        send(v, w);
        repeat (9) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, MDU ? 32'd1 : 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy",      {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v.name = "divu_after";
        send(v, w);
        v = vecs[32];
        v.name = "remu_after"; v.a = 32'd100; v.b = 32'd7; v.res = 32'd2;
        send(v, w);
        idle_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
